// File: rtl/dcache_direct.sv
// Direct-mapped, write-through, no-write-allocate data cache with 16-word line refill.
// Optional DCACHE_STATS_EN adds saturating hit_count/miss_count outputs.
module dcache_direct #(
  parameter int unsigned INDEX_W  = 6,
  parameter int unsigned MEM_WAIT = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [31:0]  address,
  input  logic         read,
  input  logic         write,
  input  logic [31:0]  write_data,
  output logic [31:0]  read_data,
  output logic         stall,
  output logic [31:0]  mem_address,
  output logic         mem_write,
  output logic [31:0]  mem_write_data,
  input  logic [511:0] fill_data
`ifdef DCACHE_STATS_EN
  ,
  output logic [31:0]  hit_count,
  output logic [31:0]  miss_count
`endif
);

  localparam int unsigned LINES = 1 << INDEX_W;
  localparam int unsigned TAG_W = 26 - INDEX_W;
  localparam int unsigned CNT_W = (MEM_WAIT > 1) ? $clog2(MEM_WAIT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_WAIT - 1);

  typedef enum logic [1:0] {IDLE, FILL, WSTORE} state_t;

  state_t             r_state;
  state_t             w_next;
  logic [CNT_W-1:0]   r_cnt;
  logic [LINES-1:0]   r_valid;
  logic [TAG_W-1:0]   r_tag  [LINES];
  logic [31:0]        r_data [LINES][16];

  logic [3:0]         w_off;
  logic [INDEX_W-1:0] w_idx;
  logic [TAG_W-1:0]   w_tag;
  logic               w_hit;
  logic               w_last;

  assign w_off  = address[5:2];
  assign w_idx  = address[5+INDEX_W:6];
  assign w_tag  = address[31:6+INDEX_W];
  assign w_hit  = r_valid[w_idx] && (r_tag[w_idx] == w_tag);
  assign w_last = (r_cnt == CNT_LAST);

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (write)               w_next = WSTORE;
        else if (read && !w_hit) w_next = FILL;
      end
      FILL, WSTORE: if (w_last) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Counter restarts on every state change and stays at zero in IDLE.
  always_ff @(posedge clk) begin
    if (rst || (w_next != r_state) || (r_state == IDLE)) r_cnt <= '0;
    else                                                 r_cnt <= r_cnt + CNT_W'(1);
  end

  always_comb begin
    stall          = 1'b0;
    mem_write      = 1'b0;
    mem_address    = address;
    mem_write_data = '0;
    read_data      = '0;
    if (!rst) begin
      case (r_state)
        IDLE: stall = write || (read && !w_hit);
        FILL: begin
          stall       = 1'b1;
          mem_address = {address[31:6], 6'b0};
        end
        WSTORE: begin
          stall          = !w_last;
          mem_write      = 1'b1;
          mem_write_data = write_data;
        end
        default: ;
      endcase
      if (read && w_hit) read_data = r_data[w_idx][w_off];
    end
  end

  always_ff @(posedge clk) begin
    if (rst)                             r_valid        <= '0;
    else if ((r_state == FILL) && w_last) r_valid[w_idx] <= 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      if ((r_state == FILL) && w_last) begin
        r_tag[w_idx] <= w_tag;
        for (int unsigned i = 0; i < 16; i++)
          r_data[w_idx][i] <= fill_data[32*i +: 32];
      end else if ((r_state == WSTORE) && w_last && w_hit) begin
        r_data[w_idx][w_off] <= write_data;
      end
    end
  end

`ifdef DCACHE_STATS_EN
  logic w_hit_evt;
  logic w_miss_evt;

  // A read only counts when write does not take priority over it.
  assign w_hit_evt  = (r_state == IDLE) && read && !write && w_hit;
  assign w_miss_evt = (r_state == IDLE) && read && !write && !w_hit;

  always_ff @(posedge clk) begin
    if (rst) begin
      hit_count  <= '0;
      miss_count <= '0;
    end else begin
      if (w_hit_evt && (hit_count != '1))   hit_count  <= hit_count + 32'd1;
      if (w_miss_evt && (miss_count != '1)) miss_count <= miss_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_dcache_direct.sv
// Directed, table-driven bench for dcache_direct with a word-addressed memory model.
module tb_dcache_direct;

  localparam int unsigned MW = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic [31:0]  address;
  logic         read;
  logic         write;
  logic [31:0]  write_data;
  logic [31:0]  read_data;
  logic         stall;
  logic [31:0]  mem_address;
  logic         mem_write;
  logic [31:0]  mem_write_data;
  logic [511:0] fill_data;
`ifdef DCACHE_STATS_EN
  logic [31:0]  hit_count;
  logic [31:0]  miss_count;
`endif

  dcache_direct #(.INDEX_W(6), .MEM_WAIT(MW)) dut (
    .clk(clk), .rst(rst), .address(address), .read(read), .write(write),
    .write_data(write_data), .read_data(read_data), .stall(stall),
    .mem_address(mem_address), .mem_write(mem_write),
    .mem_write_data(mem_write_data), .fill_data(fill_data)
`ifdef DCACHE_STATS_EN
    , .hit_count(hit_count), .miss_count(miss_count)
`endif
  );

  always #5 clk = ~clk;

  logic [31:0] mem [4096];
  logic        preload;

  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 4096; i++)
        mem[i] <= (i == 16) ? 32'hDEAD_BEEF : {16'hC0DE, 16'(i)};
    end else if (mem_write) begin
      mem[mem_address[13:2]] <= mem_write_data;
    end
  end

  always_comb begin
    fill_data = '0;
    for (int i = 0; i < 16; i++)
      fill_data[32*i +: 32] = mem[{mem_address[13:6], 4'(i)}];
  end

  int n_pass = 0;
  int n_tot  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
    else             n_pass++;
  endtask

  // Stall-high cycles, cycles with the matching memory write, and read_data when stall drops.
  task automatic op(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] wd,
                    output int ns, output int nmw, output logic [31:0] rdv);
    @(negedge clk);
    read = rd; write = wr; address = a; write_data = wd;
    #1;
    ns = 0; nmw = 0;
    while (stall && ns < 50) begin
      if (mem_write && mem_address == a && mem_write_data == wd) nmw++;
      @(negedge clk); #1;
      ns++;
    end
    if (mem_write && mem_address == a && mem_write_data == wd) nmw++;
    rdv = read_data;
    @(negedge clk);
    read = 1'b0; write = 1'b0;
  endtask

  typedef struct {
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wd;
    int          stalls;
    int          mws;
    logic [31:0] rdata;
  } vec_t;

  vec_t vt[14];

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    int          ns, nmw;
    logic [31:0] rdv;

    vt[0]  = '{1'b1, 1'b0, 32'h0000_0044, 32'h0,          MW+1, 0,  32'hC0DE_0011}; // cold miss
    vt[1]  = '{1'b1, 1'b0, 32'h0000_007C, 32'h0,          0,    0,  32'hC0DE_001F}; // same line hit
    vt[2]  = '{1'b1, 1'b0, 32'h0000_0040, 32'h0,          0,    0,  32'hDEAD_BEEF};
    vt[3]  = '{1'b0, 1'b1, 32'h0000_0048, 32'h1234_5678,  MW,   MW, 32'h0};         // store hit
    vt[4]  = '{1'b1, 1'b0, 32'h0000_0048, 32'h0,          0,    0,  32'h1234_5678};
    vt[5]  = '{1'b0, 1'b1, 32'h0000_1000, 32'hA5A5_A5A5,  MW,   MW, 32'h0};         // store miss
    vt[6]  = '{1'b1, 1'b0, 32'h0000_1000, 32'h0,          MW+1, 0,  32'hA5A5_A5A5}; // no allocate
    vt[7]  = '{1'b1, 1'b0, 32'h0000_1000, 32'h0,          0,    0,  32'hA5A5_A5A5};
    vt[8]  = '{1'b1, 1'b0, 32'h0000_1040, 32'h0,          MW+1, 0,  32'hC0DE_0410}; // conflict
    vt[9]  = '{1'b1, 1'b0, 32'h0000_0040, 32'h0,          MW+1, 0,  32'hDEAD_BEEF}; // evicted
    vt[10] = '{1'b1, 1'b0, 32'h0000_0048, 32'h0,          0,    0,  32'h1234_5678};
    vt[11] = '{1'b1, 1'b0, 32'h0000_1044, 32'h0,          MW+1, 0,  32'hC0DE_0411};
    vt[12] = '{1'b1, 1'b1, 32'h0000_0080, 32'h0000_0077,  MW,   MW, 32'h0};         // write priority
    vt[13] = '{1'b1, 1'b0, 32'h0000_0080, 32'h0,          MW+1, 0,  32'h0000_0077};

    // Reset: outputs forced quiet even with both requests asserted.
    rst = 1'b1; preload = 1'b1;
    read = 1'b1; write = 1'b1; address = 32'h44; write_data = 32'hFFFF_FFFF;
    repeat (2) @(negedge clk);
    #1;
    check("rst_stall",     32'(stall),     32'h0);
    check("rst_mem_write", 32'(mem_write), 32'h0);
    check("rst_read_data", read_data,      32'h0);
    check("rst_mem_wdata", mem_write_data, 32'h0);
    @(negedge clk);
    rst = 1'b0; preload = 1'b0; read = 1'b0; write = 1'b0;

    for (int i = 0; i < 14; i++) begin
      op(vt[i].rd, vt[i].wr, vt[i].addr, vt[i].wd, ns, nmw, rdv);
      check($sformatf("v%0d_stall_cycles", i), 32'(ns),  32'(vt[i].stalls));
      check($sformatf("v%0d_mem_writes", i),   32'(nmw), 32'(vt[i].mws));
      check($sformatf("v%0d_read_data", i),    rdv,      vt[i].rdata);
    end

`ifdef DCACHE_STATS_EN
    // Six misses; every read that retires in IDLE (six refilled retries included) is a hit.
    check("stats_hit_count",  hit_count,  32'd11);
    check("stats_miss_count", miss_count, 32'd6);
`endif

    // Reset in the second FILL cycle aborts the refill.
    @(negedge clk);
    read = 1'b1; address = 32'h0000_2004;
    #1;
    check("midfill_req_stall", 32'(stall), 32'h1);
    @(negedge clk); #1;
    check("midfill_fill_addr", mem_address, 32'h0000_2000);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("midfill_rst_stall",     32'(stall),     32'h0);
    check("midfill_rst_mem_write", 32'(mem_write), 32'h0);
    @(negedge clk);
    rst = 1'b0; read = 1'b0;
`ifdef DCACHE_STATS_EN
    #1;
    check("stats_hit_clear",  hit_count,  32'h0);
    check("stats_miss_clear", miss_count, 32'h0);
`endif

    op(1'b1, 1'b0, 32'h0000_2004, 32'h0, ns, nmw, rdv);
    check("after_rst_miss_stall", 32'(ns), 32'(MW + 1));
    check("after_rst_miss_data",  rdv,     32'hC0DE_0801);
    op(1'b1, 1'b0, 32'h0000_0044, 32'h0, ns, nmw, rdv);
    check("valid_cleared_stall", 32'(ns), 32'(MW + 1));
    check("valid_cleared_data",  rdv,     32'hC0DE_0011);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
